frame_sequencer: RTL

//  Sequences window_buffer for the MFCC front end. Waits for each frame to be filled,

---
 rtl/frame_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/frame_sequencer.sv
// frame_sequencer
// Sequences window_buffer for the MFCC front end. It waits until a frame has been
// filled, then streams FRAME_SIZE samples from the buffer in index order to the
// Hamming stage over a valid/ready interface. After the last sample is accepted it
// pulses a one-cycle start_move so the buffer advances its window, and it repeats
// this while enable_i stays high. The block owns the frame cadence of the pipeline.
//
// Ports
//   clk              clock
//   rst_n            asynchronous reset, active-low
//   enable_i         level; run frames while high (sampled in IDLE and at WAIT_MOVE exit)
//   wb_idle_i        window_buffer idle: frame filled/moved and contents stable
//   wb_start_move_o  one-cycle pulse: shift the window by MOVE_SIZE
//   wb_rd_en_o       read strobe to window_buffer
//   wb_rd_idx_o      frame-relative sample index of the read
//   wb_data_i        read data, valid exactly one cycle after wb_rd_en_o
//   smp_valid_o      sample valid to the Hamming stage
//   smp_data_o       sample
//   smp_last_o       high with sample index FRAME_SIZE-1
//   smp_ready_i      Hamming stage accepts the sample
//   frame_done_o     one-cycle pulse when the last sample is accepted
//   busy_o           sequencer is not idle
//
// Optional feature: define FRAME_SEQ_STATS_EN to add
//   frame_count_o    frames completed, wraps at 2^32
//   stall_count_o    cycles with smp_valid_o=1 and smp_ready_i=0, saturating

module frame_sequencer #(
  parameter int  WIDTH      = 16,
  parameter int  FRAME_SIZE = 400,
  localparam int IDX_W      = $clog2(FRAME_SIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic             wb_idle_i,
  output logic             wb_start_move_o,
  output logic             wb_rd_en_o,
  output logic [IDX_W-1:0] wb_rd_idx_o,
  input  logic [WIDTH-1:0] wb_data_i,
  output logic             smp_valid_o,
  output logic [WIDTH-1:0] smp_data_o,
  output logic             smp_last_o,
  input  logic             smp_ready_i,
  output logic             frame_done_o,
  output logic             busy_o
`ifdef FRAME_SEQ_STATS_EN
  ,
  output logic [31:0]      frame_count_o,
  output logic [31:0]      stall_count_o
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FILL,
    S_STREAM,
    S_DRAIN,
    S_MOVE,
    S_WAIT_MOVE
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wm_first_q, wm_first_d;

  // Read issued last cycle; its data is on wb_data_i this cycle.
  logic             rd_pend_q;
  logic             rd_last_pend_q;

  // Two-entry output FIFO; the head drives the smp_* interface.
  logic [WIDTH-1:0] fifo_data_q [0:1];
  logic [1:0]       fifo_last_q;
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       count_q;

  logic             pop;
  logic             issue;
  logic             last_idx;
  logic [1:0]       occupancy;

  assign last_idx    = (idx_q == LAST_IDX);
  assign smp_valid_o = (count_q != 2'd0);
  assign pop         = smp_valid_o & smp_ready_i;

  // Slots committed once this cycle's pop leaves: reads in flight plus held entries.
  // Crediting the pop in the same cycle keeps a 1 sample/cycle stream going with
  // ready held high, while occupancy can never exceed the two FIFO entries.
  assign occupancy = count_q + {1'b0, rd_pend_q} - {1'b0, pop};

  assign wb_rd_en_o  = issue;
  assign wb_rd_idx_o = idx_q;
  assign smp_data_o  = smp_valid_o ? fifo_data_q[rd_ptr_q] : '0;
  assign smp_last_o  = smp_valid_o & fifo_last_q[rd_ptr_q];
  assign busy_o      = (state_q != S_IDLE);

  // Next-state logic and the state-derived strobes.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    wm_first_d      = 1'b0;
    issue           = 1'b0;
    wb_start_move_o = 1'b0;
    frame_done_o    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable_i) state_d = S_WAIT_FILL;
      end
      S_WAIT_FILL: begin
        if (wb_idle_i) begin
          state_d = S_STREAM;
          idx_d   = '0;
        end
      end
      S_STREAM: begin
        if (occupancy < 2'd2) begin
          issue = 1'b1;
          if (last_idx) state_d = S_DRAIN;
          else          idx_d   = idx_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (pop && fifo_last_q[rd_ptr_q]) begin
          frame_done_o = 1'b1;
          state_d      = S_MOVE;
        end
      end
      S_MOVE: begin
        wb_start_move_o = 1'b1;
        wm_first_d      = 1'b1;
        state_d         = S_WAIT_MOVE;
      end
      S_WAIT_MOVE: begin
        // The buffer may still report idle on the first cycle after the move pulse.
        if (!wm_first_q && wb_idle_i) begin
          idx_d   = '0;
          state_d = enable_i ? S_STREAM : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      wm_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wm_first_q <= wm_first_d;
    end
  end

  // Read tracking and output FIFO; read data is captured the cycle after the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q      <= 1'b0;
      rd_last_pend_q <= 1'b0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q    <= '0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
    end else begin
      rd_pend_q      <= issue;
      rd_last_pend_q <= issue & last_idx;
      if (rd_pend_q) begin
        fifo_data_q[wr_ptr_q] <= wb_data_i;
        fifo_last_q[wr_ptr_q] <= rd_last_pend_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, rd_pend_q} - {1'b0, pop};
    end
  end

`ifdef FRAME_SEQ_STATS_EN
  logic [31:0] frame_count_q;
  logic [31:0] stall_count_q;

  // Frame counter wraps; stall counter sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      if (frame_done_o) frame_count_q <= frame_count_q + 32'd1;
      if (smp_valid_o && !smp_ready_i && (stall_count_q != 32'hFFFF_FFFF))
        stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign frame_count_o = frame_count_q;
  assign stall_count_o = stall_count_q;
`endif

endmodule
